// File: rtl/seq_div.sv
// Sequential restoring divider: N-bit unsigned dividend / D-bit unsigned divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: short-circuit a zero divisor to DONE one edge after the accept.
module seq_div #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    input  logic         load,
    output logic [N-1:0] quo,
    output logic [D-1:0] rem,
    output logic         ready_out,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_reg, state_next;
    // work_reg shifts the dividend out of its MSB while quotient bits enter at its LSB
    logic [N-1:0]   work_reg, work_next;
    logic [D-1:0]   divisor_reg, divisor_next;
    logic [D:0]     prem_reg, prem_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N-1:0]   quo_reg, quo_next;
    logic [D-1:0]   rem_reg, rem_next;
    logic           ready_reg, ready_next;

    logic [D:0]     prem_shift;
    logic [D:0]     prem_sub;
    logic           q_bit;
    logic [N-1:0]   work_shift;

`ifdef DIV_ZERO_DETECT_EN
    logic           dbz_reg, dbz_next;
`endif

    // One restoring step; the partial remainder stays below the divisor,
    // so the shifted value always fits in D+1 bits.
    always_comb begin
        prem_shift = {prem_reg[D-1:0], work_reg[N-1]};
        q_bit      = (prem_shift >= {1'b0, divisor_reg});
        prem_sub   = q_bit ? (prem_shift - {1'b0, divisor_reg}) : prem_shift;
        work_shift = (work_reg << 1) | N'(q_bit);
    end

    always_comb begin
        state_next   = state_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        prem_next    = prem_reg;
        cnt_next     = cnt_reg;
        quo_next     = quo_reg;
        rem_next     = rem_reg;
        ready_next   = ready_reg;
`ifdef DIV_ZERO_DETECT_EN
        dbz_next     = dbz_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                if (load) begin
                    work_next    = dividend;
                    divisor_next = divisor;
                    prem_next    = '0;
                    cnt_next     = CNT_LAST;
                    ready_next   = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    dbz_next     = 1'b0;
`endif
                    state_next   = BUSY;
                end
            end
            BUSY: begin
`ifdef DIV_ZERO_DETECT_EN
                if (divisor_reg == '0) begin
                    // work_reg still holds the untouched dividend on the first BUSY edge
                    quo_next   = '1;
                    rem_next   = work_reg[D-1:0];
                    ready_next = 1'b1;
                    dbz_next   = 1'b1;
                    state_next = DONE;
                end else
`endif
                begin
                    prem_next = prem_sub;
                    work_next = work_shift;
                    cnt_next  = cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        quo_next   = work_shift;
                        rem_next   = prem_sub[D-1:0];
                        ready_next = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            work_reg    <= '0;
            divisor_reg <= '0;
            prem_reg    <= '0;
            cnt_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            ready_reg   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_reg     <= 1'b0;
`endif
        end else begin
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            prem_reg    <= prem_next;
            cnt_reg     <= cnt_next;
            quo_reg     <= quo_next;
            rem_reg     <= rem_next;
            ready_reg   <= ready_next;
`ifdef DIV_ZERO_DETECT_EN
            dbz_reg     <= dbz_next;
`endif
        end
    end

    assign quo       = quo_reg;
    assign rem       = rem_reg;
    assign ready_out = ready_reg;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_reg;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus random operands against an arithmetic reference.
module tb_seq_div;

    localparam int N = 8;
    localparam int D = 4;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_a;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         load;
    logic [N-1:0] quo;
    logic [D-1:0] rem;
    logic         ready_out;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_div #(.N(N), .D(D)) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .dividend    (dividend),
        .divisor     (divisor),
        .load        (load),
        .quo         (quo),
        .rem         (rem),
        .ready_out   (ready_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands with load for exactly one rising edge; return at the negedge after it.
    task automatic accept(input int a, input int b);
        @(negedge clk);
        dividend = N'(a);
        divisor  = D'(b);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called at a negedge 'pre' edges after an accept; waits for the result and checks it.
    task automatic finish_op(input int a, input int b, input string tag, input int pre);
        int exp_q, exp_r, exp_lat, lat;
        logic [N-1:0] old_q;
        logic [D-1:0] old_r;
        bit held_ok;
        if (b == 0) begin
            exp_q = (1 << N) - 1;
            exp_r = a % (1 << D);
        end else begin
            exp_q = a / b;
            exp_r = a % b;
        end
        exp_lat = (b == 0 && DZ) ? 1 : N;
        check({tag, "_rdy_low"}, 32'(ready_out), 0);
        old_q   = quo;
        old_r   = rem;
        held_ok = 1'b1;
        lat     = pre;
        while (!ready_out && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!ready_out && (quo !== old_q || rem !== old_r)) held_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_quo"}, 32'(quo), 32'(exp_q));
        check({tag, "_rem"}, 32'(rem), 32'(exp_r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(DZ && b == 0));
        check({tag, "_no_intermediate"}, 32'(held_ok), 1);
        $display("op %s: %0d/%0d -> quo=%0d rem=%0d dbz=%0d latency=%0d", tag, a, b, quo, rem, div_by_zero, lat);
    endtask

    initial begin
        rst_a    = 1'b1;
        load     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_quo", 32'(quo), 0);
        check("reset_rem", 32'(rem), 0);
        check("reset_ready", 32'(ready_out), 0);
        check("reset_dbz", 32'(div_by_zero), 0);
        rst_a = 1'b0;

        accept(200, 7);
        finish_op(200, 7, "d200_7", 0);

        // load held high through DONE restarts with whatever operands are present
        @(negedge clk);
        dividend = 8'd6;
        divisor  = 4'd3;
        load     = 1'b1;
        @(negedge clk);
        finish_op(6, 3, "hold_6_3", 0);
        dividend = 8'd9;
        @(negedge clk);
        load = 1'b0;
        check("restart_ready_drop", 32'(ready_out), 0);
        check("restart_quo_held", 32'(quo), 2);
        finish_op(9, 3, "hold_9_3", 0);

        accept(5, 9);
        finish_op(5, 9, "d5_9", 0);
        accept(255, 15);
        finish_op(255, 15, "d255_15", 0);
        accept(13, 0);
        finish_op(13, 0, "d13_0", 0);

        // load and operand change during BUSY must be ignored
        accept(100, 7);
        repeat (2) @(negedge clk);
        dividend = 8'd201;
        divisor  = 4'd1;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        finish_op(100, 7, "pulse_100_7", 3);

        // asynchronous reset in the middle of an operation
        accept(77, 6);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("midrst_quo", 32'(quo), 0);
        check("midrst_rem", 32'(rem), 0);
        check("midrst_ready", 32'(ready_out), 0);
        check("midrst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_idle_ready", 32'(ready_out), 0);
        check("midrst_idle_quo", 32'(quo), 0);
        accept(50, 5);
        finish_op(50, 5, "d50_5", 0);

        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << N) - 1));
            b = (i % 7 == 3) ? 0 : int'($urandom_range(0, (1 << D) - 1));
            accept(a, b);
            finish_op(a, b, "rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider: an N-bit unsigned dividend divided by a D-bit unsigned divisor, producing one quotient bit per clock. It is the inverse-direction companion to the sequential multiplier in the arithmetic datapath and uses the same load / ready_out operand handshake. Results stay registered until the next accepted load.

## Interface
- N, default 8: dividend and quotient width.
- D, default 4: divisor and remainder width; D ≤ N.
- clk  input  1  rising-edge clock.
- rst_a  input  1  asynchronous, active-high reset.
- dividend  input  N  unsigned dividend, sampled on an accepted load.
- divisor  input  D  unsigned divisor, sampled on an accepted load.
- load  input  1  start request, level-sampled on the rising clk edge.
- quo  output  N  quotient.
- rem  output  D  remainder.
- ready_out  output  1  result valid; high in DONE.
- div_by_zero  output  1  last result came from a zero divisor; see Configuration.

## Operation
- FSM states:
  - IDLE: reset state.
  - BUSY: iterating.
  - DONE: result valid.
- Accept condition: load=1 at a rising edge while in IDLE or DONE. On accept:
  - capture dividend and divisor;
  - clear the internal (D+1)-bit partial remainder;
  - set bit counter to N-1;
  - drop ready_out and div_by_zero;
  - go to BUSY.
- load in BUSY is ignored; operands on the inputs are don't-care after the accept edge.
- Each BUSY edge:
  - shift the next dividend bit (MSB first) into the partial remainder;
  - if the partial remainder ≥ divisor, subtract the divisor and shift a 1 into the quotient; otherwise shift in a 0;
  - decrement the counter.
- On the BUSY edge with counter = 0:
  - write quo and rem (low D bits of the partial remainder);
  - set ready_out=1;
  - go to DONE.
- DONE holds quo, rem and ready_out until the next accept. load held high in DONE restarts immediately with the current operands.
- quo and rem change only on completion edges and never show intermediate values.
- Arithmetic identity for a nonzero divisor: dividend = quo·divisor + rem, with rem < divisor.
- Zero divisor: the result is quo = all ones and rem = dividend[D-1:0], whether or not DIV_ZERO_DETECT_EN is defined.
- Reset (rst_a=1, any time including mid-BUSY), effective immediately:
  - state = IDLE;
  - quo = 0, rem = 0;
  - ready_out = 0, div_by_zero = 0;
  - internal registers cleared.

## Timing
- Accept at edge k with a nonzero divisor: BUSY during edges k+1 … k+N. ready_out rises after edge k+N, giving N cycles of latency (8 by default).
- Zero divisor with DIV_ZERO_DETECT_EN defined: ready_out rises after edge k+1.
- ready_out falls after the accept edge of the next operation.
- Back-to-back throughput: one result every N+1 cycles with load held high.
- First accept after reset release: the first rising edge with rst_a=0 and load=1.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - on an accept with divisor = 0, skip BUSY;
  - at the next edge, write quo = all ones and rem = dividend[D-1:0], set div_by_zero=1 and ready_out=1, and go to DONE.
- DIV_ZERO_DETECT_EN undefined:
  - div_by_zero is tied to 0;
  - a zero divisor runs the normal N-cycle iteration, which yields the same quo and rem values.

## Test plan
- Reset, release, load with 200/7 -> ready_out after 8 edges, quo=28, rem=4, div_by_zero=0.
- 6/3, then load held high through DONE with 9/3 applied -> quo=2 rem=0, then ready_out drops and quo=3 rem=0 after 8 more edges.
- 5/9 and 255/15 -> quo=0 rem=5; quo=17 rem=0.
- 13/0 -> with DIV_ZERO_DETECT_EN: ready_out after 1 edge, quo=255, rem=13, div_by_zero=1. Without it: same quo and rem after 8 edges, div_by_zero=0.
- 100/7 with load pulsed again and operands changed at cycle 3 of BUSY -> change ignored, quo=14 rem=2 after 8 edges.
- rst_a asserted at cycle 4 of BUSY -> outputs 0 immediately, state IDLE. A new load of 50/5 then gives quo=10 rem=0.
